fifo_rd_ctrl: RTL and testbench

//  Read-side controller for the 8-entry x 32-bit FIFO register bank. It

---
 rtl/fifo_rd_ctrl.sv | 130 +++++++++++++
 tb/tb_fifo_rd_ctrl.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/fifo_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rd_ctrl
// Brief    : Read-side controller for the 8x32 FIFO register bank; owns the
//            read pointer, occupancy count and registered read data/ack/error.
// Revision : 1.0
// ============================================================================
module fifo_rd_ctrl #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             rd_en,
  input  logic             wr_commit,
  input  logic [WIDTH-1:0] reg_in0,
  input  logic [WIDTH-1:0] reg_in1,
  input  logic [WIDTH-1:0] reg_in2,
  input  logic [WIDTH-1:0] reg_in3,
  input  logic [WIDTH-1:0] reg_in4,
  input  logic [WIDTH-1:0] reg_in5,
  input  logic [WIDTH-1:0] reg_in6,
  input  logic [WIDTH-1:0] reg_in7,
  output logic [WIDTH-1:0] d_out,
  output logic [2:0]       rd_ptr,
  output logic [3:0]       data_count,
  output logic             empty,
  output logic             full,
  output logic             rd_ack,
  output logic             rd_err,
  output logic [1:0]       state
);

  localparam logic [3:0] C_FULL_COUNT = 4'(DEPTH);

  typedef enum logic [1:0] {
    ST_INIT     = 2'b00,
    ST_NO_OP    = 2'b01,
    ST_READ     = 2'b10,
    ST_RD_ERROR = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] d_out_q, d_out_d;
  logic [2:0]       rd_ptr_q, rd_ptr_d;
  logic [3:0]       count_q, count_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic             rd_ack_q, rd_ack_d;
  logic             rd_err_q, rd_err_d;
  logic             rd_acc;
  logic [WIDTH-1:0] bank [DEPTH];

  always_comb begin
    bank[0] = reg_in0;
    bank[1] = reg_in1;
    bank[2] = reg_in2;
    bank[3] = reg_in3;
    bank[4] = reg_in4;
    bank[5] = reg_in5;
    bank[6] = reg_in6;
    bank[7] = reg_in7;
  end

  // Same transition rules apply from every state, INIT included.
  always_comb begin
    rd_acc   = rd_en && (count_q != 4'd0);
    state_d  = ST_NO_OP;
    d_out_d  = d_out_q;
    rd_ptr_d = rd_ptr_q;
    rd_ack_d = 1'b0;
    rd_err_d = 1'b0;
    count_d  = count_q;

    if (rd_en) begin
      if (rd_acc) begin
        state_d  = ST_READ;
        d_out_d  = bank[rd_ptr_q];
        rd_ptr_d = rd_ptr_q + 3'd1;
        rd_ack_d = 1'b1;
      end else begin
        state_d  = ST_RD_ERROR;
        rd_err_d = 1'b1;
      end
    end

    // A commit while full is a writer fault and is dropped.
    if (wr_commit && !rd_acc) begin
      if (count_q != C_FULL_COUNT) count_d = count_q + 4'd1;
    end else if (!wr_commit && rd_acc) begin
      count_d = count_q - 4'd1;
    end

    empty_d = (count_d == 4'd0);
    full_d  = (count_d == C_FULL_COUNT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_INIT;
      d_out_q  <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      rd_ack_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      d_out_q  <= d_out_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      rd_ack_q <= rd_ack_d;
      rd_err_q <= rd_err_d;
    end
  end

  assign d_out      = d_out_q;
  assign rd_ptr     = rd_ptr_q;
  assign data_count = count_q;
  assign empty      = empty_q;
  assign full       = full_q;
  assign rd_ack     = rd_ack_q;
  assign rd_err     = rd_err_q;
  assign state      = state_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_rd_ctrl
// Brief    : Directed self-checking bench for fifo_rd_ctrl.
// Revision : 1.0
// ============================================================================
module tb_fifo_rd_ctrl;

  localparam logic [1:0] C_INIT = 2'b00, C_NOOP = 2'b01, C_READ = 2'b10, C_ERR = 2'b11;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rd_en = 1'b0;
  logic        wr_commit = 1'b0;
  logic [31:0] reg_in [8];
  logic [31:0] d_out;
  logic [2:0]  rd_ptr;
  logic [3:0]  data_count;
  logic        empty, full, rd_ack, rd_err;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_rd_ctrl #(.WIDTH(32), .DEPTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .rd_en(rd_en), .wr_commit(wr_commit),
    .reg_in0(reg_in[0]), .reg_in1(reg_in[1]), .reg_in2(reg_in[2]), .reg_in3(reg_in[3]),
    .reg_in4(reg_in[4]), .reg_in5(reg_in[5]), .reg_in6(reg_in[6]), .reg_in7(reg_in[7]),
    .d_out(d_out), .rd_ptr(rd_ptr), .data_count(data_count), .empty(empty),
    .full(full), .rd_ack(rd_ack), .rd_err(rd_err), .state(state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic chk_status(input string tag, input logic [3:0] cnt, input logic [2:0] ptr,
                            input logic ack, input logic err, input logic [1:0] st);
    check({tag, ".count"}, 32'(data_count), 32'(cnt));
    check({tag, ".empty"}, 32'(empty), 32'(cnt == 4'd0));
    check({tag, ".full"},  32'(full),  32'(cnt == 4'd8));
    check({tag, ".ptr"},   32'(rd_ptr), 32'(ptr));
    check({tag, ".ack"},   32'(rd_ack), 32'(ack));
    check({tag, ".err"},   32'(rd_err), 32'(err));
    check({tag, ".state"}, 32'(state),  32'(st));
  endtask

  initial begin
    for (int i = 0; i < 8; i++) reg_in[i] = $urandom;

    // Reset with random activity on the inputs
    for (int i = 0; i < 4; i++) begin
      rd_en = 1'($urandom); wr_commit = 1'($urandom);
      tick();
    end
    check("rst.d_out", d_out, 32'h0);
    chk_status("rst", 4'd0, 3'd0, 1'b0, 1'b0, C_INIT);

    rd_en = 1'b0; wr_commit = 1'b0;
    for (int i = 0; i < 8; i++) reg_in[i] = 32'hA000_0000 | 32'(i);
    reset_n = 1'b1;
    tick();
    chk_status("leave_init", 4'd0, 3'd0, 1'b0, 1'b0, C_NOOP);

    // Empty read
    rd_en = 1'b1; tick();
    chk_status("empty_rd", 4'd0, 3'd0, 1'b0, 1'b1, C_ERR);
    check("empty_rd.d_out", d_out, 32'h0);
    rd_en = 1'b0; tick();
    chk_status("empty_rd_end", 4'd0, 3'd0, 1'b0, 1'b0, C_NOOP);

    // Fill then drain with one extra read
    wr_commit = 1'b1; ticks(8); wr_commit = 1'b0;
    chk_status("fill", 4'd8, 3'd0, 1'b0, 1'b0, C_NOOP);
    rd_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("drain.d_out", d_out, 32'hA000_0000 | 32'(i));
      chk_status("drain", 4'(7 - i), 3'((i + 1) % 8), 1'b1, 1'b0, C_READ);
    end
    tick();
    check("over.d_out", d_out, 32'hA000_0007);
    chk_status("over", 4'd0, 3'd0, 1'b0, 1'b1, C_ERR);
    rd_en = 1'b0; tick();

    // Pointer wrap: advance pointer to 7, then read entries 7 and 0
    wr_commit = 1'b1; ticks(7); wr_commit = 1'b0;
    rd_en = 1'b1; ticks(7); rd_en = 1'b0;
    chk_status("pre_wrap", 4'd0, 3'd7, 1'b1, 1'b0, C_READ);
    wr_commit = 1'b1; ticks(2); wr_commit = 1'b0;
    rd_en = 1'b1; tick();
    check("wrap0.d_out", d_out, 32'hA000_0007);
    chk_status("wrap0", 4'd1, 3'd0, 1'b1, 1'b0, C_READ);
    tick();
    check("wrap1.d_out", d_out, 32'hA000_0000);
    chk_status("wrap1", 4'd0, 3'd1, 1'b1, 1'b0, C_READ);
    rd_en = 1'b0; tick();

    // Simultaneous read and write, mid, empty and full
    wr_commit = 1'b1; ticks(3);
    rd_en = 1'b1; tick();
    check("sim3.d_out", d_out, 32'hA000_0001);
    chk_status("sim3", 4'd3, 3'd2, 1'b1, 1'b0, C_READ);
    wr_commit = 1'b0; ticks(3);
    chk_status("sim_drain", 4'd0, 3'd5, 1'b1, 1'b0, C_READ);
    rd_en = 1'b0; tick();
    rd_en = 1'b1; wr_commit = 1'b1; tick();
    chk_status("sim_empty", 4'd1, 3'd5, 1'b0, 1'b1, C_ERR);
    rd_en = 1'b0; ticks(7);
    chk_status("refill", 4'd8, 3'd5, 1'b0, 1'b0, C_NOOP);
    rd_en = 1'b1; tick();
    check("sim_full.d_out", d_out, 32'hA000_0005);
    chk_status("sim_full", 4'd8, 3'd6, 1'b1, 1'b0, C_READ);
    rd_en = 1'b0; tick();
    chk_status("wr_when_full", 4'd8, 3'd6, 1'b0, 1'b0, C_NOOP);
    wr_commit = 1'b0;

    // Asynchronous reset during a read
    rd_en = 1'b1; ticks(3);
    chk_status("pre_rst", 4'd5, 3'd1, 1'b1, 1'b0, C_READ);
    tick();
    check("mid.ack", 32'(rd_ack), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    check("async.d_out", d_out, 32'h0);
    chk_status("async", 4'd0, 3'd0, 1'b0, 1'b0, C_INIT);
    tick();
    chk_status("held", 4'd0, 3'd0, 1'b0, 1'b0, C_INIT);
    reset_n = 1'b1; tick();
    chk_status("rel_rd", 4'd0, 3'd0, 1'b0, 1'b1, C_ERR);
    rd_en = 1'b0; tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
